// File: rtl/adsr_poly.sv
// Time-multiplexed ADSR envelope engine: per-voice {env, state, key} in a small
// array, visited by a 4-phase pipeline, with a note-event FIFO feeding key updates.
module adsr_poly #(
  parameter int NUM_VOICES = 32,
  parameter int ADDR_W     = 8,
  parameter int SAMPLE_W   = 16,
  parameter int ENV_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_note_valid,
  input  logic                i_note_on,
  input  logic [ADDR_W-1:0]   i_note_voice,
  input  logic [ADDR_W-1:0]   i_voice_index,
  input  logic [1:0]          i_pipeline_state,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [15:0]         i_attack_amt,
  input  logic [15:0]         i_decay_amt,
  input  logic [15:0]         i_sustain_amt,
  input  logic [15:0]         i_rel_amt,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_voice_index,
  output logic                o_ready,
  output logic                o_overflow
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUM_VOICES);
  localparam logic [ENV_W:0]  MAX_X    = {1'b0, {ENV_W{1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_DECAY, ST_RELEASE} vstate_e;
  typedef struct packed { logic on; logic [ADDR_W-1:0] voice; } note_t;

  logic [ENV_W-1:0] env_mem [NUM_VOICES];
  vstate_e          st_mem  [NUM_VOICES];
  logic             key_mem [NUM_VOICES];
  note_t            fifo_mem [FIFO_DEPTH];

  logic                ready_q, ready_d;
  logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   voice_q, voice_d;
  logic                ovf_q, ovf_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [ENV_W-1:0] rd_env_q;
  vstate_e          rd_st_q;
  logic             rd_key_q;

  logic ph_read, ph_calc, ph_evt, fifo_empty, fifo_full, pop, push_ok;
  note_t head;
  assign ph_read    = ready_q && (i_pipeline_state == 2'd0);
  assign ph_calc    = ready_q && (i_pipeline_state == 2'd1);
  assign ph_evt     = ready_q && (i_pipeline_state == 2'd2);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
  assign pop        = ph_evt && !fifo_empty;
  assign push_ok    = i_note_valid && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // Rates share the sustain scaling: the 16-bit amount lands in the top 16 env bits.
  logic [ENV_W-1:0] atk_e, dec_e, rel_e, tgt_e;
  logic [ENV_W:0]   env_x, atk_x, dec_x, rel_x, tgt_x;
  assign atk_e = ENV_W'(i_attack_amt)  << (ENV_W-16);
  assign dec_e = ENV_W'(i_decay_amt)   << (ENV_W-16);
  assign rel_e = ENV_W'(i_rel_amt)     << (ENV_W-16);
  assign tgt_e = ENV_W'(i_sustain_amt) << (ENV_W-16);
  assign env_x = {1'b0, rd_env_q};
  assign atk_x = {1'b0, atk_e};
  assign dec_x = {1'b0, dec_e};
  assign rel_x = {1'b0, rel_e};
  assign tgt_x = {1'b0, tgt_e};

  logic [ENV_W-1:0] nxt_env;
  vstate_e          nxt_st;
  always_comb begin
    nxt_env = rd_env_q;
    nxt_st  = rd_st_q;
    case (rd_st_q)
      ST_IDLE: begin
        nxt_env = '0;
        if (rd_key_q) nxt_st = ST_ATTACK;
      end
      ST_ATTACK:
        if (!rd_key_q) nxt_st = ST_RELEASE;
        else if (env_x + atk_x >= MAX_X) begin
          nxt_env = '1;
          nxt_st  = ST_DECAY;
        end else nxt_env = rd_env_q + atk_e;
      ST_DECAY:
        if (!rd_key_q) nxt_st = ST_RELEASE;
        else if (env_x > tgt_x + dec_x) nxt_env = rd_env_q - dec_e;
        else nxt_env = tgt_e;
      ST_RELEASE:
        if (rd_key_q) nxt_st = ST_ATTACK;
        else if (env_x > rel_x) nxt_env = rd_env_q - rel_e;
        else begin
          nxt_env = '0;
          nxt_st  = ST_IDLE;
        end
    endcase
  end

  logic [15:0] gain;
  logic signed [SAMPLE_W+16:0] smp_x, g_x, prod;
  assign gain  = rd_env_q[ENV_W-1 -: 16];
  assign smp_x = {{17{i_sample[SAMPLE_W-1]}}, i_sample};
  assign g_x   = {{(SAMPLE_W+1){1'b0}}, gain};
  assign prod  = smp_x * g_x;

  // Single write port per field group; key writes are masked from env/state.
  logic             env_we, key_we, key_wd;
  logic [IDX_W-1:0] env_wa, key_wa;
  logic [ENV_W-1:0] env_wd;
  vstate_e          st_wd;
  always_comb begin
    env_we = 1'b0;
    env_wa = rd_addr_q[IDX_W-1:0];
    env_wd = nxt_env;
    st_wd  = nxt_st;
    key_we = 1'b0;
    key_wa = head.voice[IDX_W-1:0];
    key_wd = head.on;
    if (!ready_q) begin
      env_we = (init_cnt_q < LAST_CNT);
      env_wa = init_cnt_q[IDX_W-1:0];
      env_wd = '0;
      st_wd  = ST_IDLE;
      key_we = env_we;
      key_wa = init_cnt_q[IDX_W-1:0];
      key_wd = 1'b0;
    end else if (ph_calc) env_we = 1'b1;
    else if (pop) key_we = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (env_we) begin
      env_mem[env_wa] <= env_wd;
      st_mem[env_wa]  <= st_wd;
    end
    if (key_we) key_mem[key_wa] <= key_wd;
    if (ph_read) begin
      rd_env_q <= env_mem[i_voice_index[IDX_W-1:0]];
      rd_st_q  <= st_mem[i_voice_index[IDX_W-1:0]];
      rd_key_q <= key_mem[i_voice_index[IDX_W-1:0]];
    end
    if (push_ok) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{on: i_note_on, voice: i_note_voice};
  end

  always_comb begin
    ready_d    = ready_q;
    init_cnt_d = init_cnt_q;
    rd_addr_d  = rd_addr_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    voice_d    = voice_q;
    ovf_d      = ovf_q | (i_note_valid && !push_ok);
    wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
    if (!ready_q) begin
      if (init_cnt_q == LAST_CNT) ready_d = 1'b1;
      else init_cnt_d = init_cnt_q + (ADDR_W+1)'(1);
    end
    if (ph_read) rd_addr_d = i_voice_index;
    if (ph_calc) begin
      sample_d = prod[SAMPLE_W+15:16];
      valid_d  = 1'b1;
      voice_d  = rd_addr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q    <= 1'b0;
      init_cnt_q <= '0;
      rd_addr_q  <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      voice_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      ready_q    <= ready_d;
      init_cnt_q <= init_cnt_d;
      rd_addr_q  <= rd_addr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      voice_q    <= voice_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{prod[SAMPLE_W+16], prod[15:0], head.voice};

  assign o_sample      = sample_q;
  assign o_valid       = valid_q;
  assign o_voice_index = voice_q;
  assign o_ready       = ready_q;
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_adsr_poly.sv
// Directed bench for adsr_poly: init sweep, table of envelope visits, FIFO
// overflow/ordering and reset-during-operation sequences.
module tb_adsr_poly;
  localparam int NV = 32, AW = 8, SW = 16, EW = 32, FD = 8;
  localparam int NROWS = 30;

  logic          i_clk = 1'b0, i_reset_n = 1'b0;
  logic          i_note_valid = 1'b0, i_note_on = 1'b0;
  logic [AW-1:0] i_note_voice = '0, i_voice_index = '0;
  logic [1:0]    i_pipeline_state = 2'd3;
  logic [SW-1:0] i_sample = '0;
  logic [15:0]   i_attack_amt = 16'h8000, i_decay_amt = 16'h1000;
  logic [15:0]   i_sustain_amt = 16'h4000, i_rel_amt = 16'h2000;
  logic [SW-1:0] o_sample;
  logic          o_valid, o_ready, o_overflow;
  logic [AW-1:0] o_voice_index;

  adsr_poly #(.NUM_VOICES(NV), .ADDR_W(AW), .SAMPLE_W(SW), .ENV_W(EW), .FIFO_DEPTH(FD)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_note_valid(i_note_valid), .i_note_on(i_note_on),
    .i_note_voice(i_note_voice), .i_voice_index(i_voice_index), .i_pipeline_state(i_pipeline_state),
    .i_sample(i_sample), .i_attack_amt(i_attack_amt), .i_decay_amt(i_decay_amt),
    .i_sustain_amt(i_sustain_amt), .i_rel_amt(i_rel_amt), .o_sample(o_sample), .o_valid(o_valid),
    .o_voice_index(o_voice_index), .o_ready(o_ready), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        pre_nv;
    logic        pre_on;
    logic [7:0]  voice;
    logic [15:0] smp;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [NROWS];

  int checks = 0, errors = 0;

  function automatic vec_t mk(input logic nv, input logic on, input logic [7:0] v,
                              input logic [15:0] s, input logic [15:0] e);
    return {nv, on, v, s, e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic on, input logic [7:0] v);
    i_note_valid = 1'b1; i_note_on = on; i_note_voice = v;
    @(negedge i_clk);
    i_note_valid = 1'b0;
  endtask

  // One full 4-phase visit; outputs are sampled in the cycle after phase 1.
  task automatic visit(input logic [7:0] v, input logic [15:0] s, input logic [15:0] exp, input string nm);
    i_voice_index = v; i_sample = s; i_pipeline_state = 2'd0;
    @(negedge i_clk);
    i_pipeline_state = 2'd1;
    @(negedge i_clk);
    chk({nm, "_smp"}, 32'(o_sample), 32'(exp));
    chk({nm, "_vld"}, 32'(o_valid), 32'd1);
    chk({nm, "_voice"}, 32'(o_voice_index), 32'(v));
    i_pipeline_state = 2'd2;
    @(negedge i_clk);
    chk({nm, "_vld_pulse"}, 32'(o_valid), 32'd0);
    i_pipeline_state = 2'd3;
    @(negedge i_clk);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk(nm, 32'(o_ready), 32'd1);
  endtask

  logic [7:0] ov_voice [8] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
  logic       ov_key   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int rise;
    logic vld_seen;

    // Voice 3 lifecycle; rates fixed at atk 0x8000, dec 0x1000, sus 0x4000, rel 0x2000.
    tbl[0]  = mk(1, 1, 3, 16'h4000, 16'h0000);
    tbl[1]  = mk(0, 0, 3, 16'h4000, 16'h0000);
    tbl[2]  = mk(0, 0, 3, 16'h4000, 16'h0000);
    tbl[3]  = mk(0, 0, 3, 16'h4000, 16'h2000);
    tbl[4]  = mk(0, 0, 3, 16'h4000, 16'h3FFF);
    for (int k = 5; k <= 15; k++) tbl[k] = mk(0, 0, 3, 16'h8000, 16'h8000 + 16'((k-4) * 'h800));
    tbl[16] = mk(0, 0, 3, 16'h8000, 16'hE000);
    tbl[17] = mk(0, 0, 3, 16'h8000, 16'hE000);
    tbl[18] = mk(1, 0, 3, 16'h8000, 16'hE000);
    tbl[19] = mk(0, 0, 3, 16'h8000, 16'hE000);
    tbl[20] = mk(0, 0, 3, 16'h8000, 16'hE000);
    tbl[21] = mk(0, 0, 3, 16'h8000, 16'hF000);
    tbl[22] = mk(1, 1, 3, 16'h8000, 16'h0000);
    tbl[23] = mk(0, 0, 3, 16'h8000, 16'h0000);
    tbl[24] = mk(1, 0, 3, 16'h8000, 16'h0000);
    tbl[25] = mk(1, 1, 3, 16'h8000, 16'hC000);
    tbl[26] = mk(0, 0, 3, 16'h8000, 16'hC000);
    tbl[27] = mk(0, 0, 3, 16'h8000, 16'hC000);
    tbl[28] = mk(0, 0, 3, 16'h8000, 16'h8000);
    tbl[29] = mk(0, 0, 5, 16'h4000, 16'h0000);

    repeat (3) @(negedge i_clk);
    chk("rst_sample", 32'(o_sample), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_voice", 32'(o_voice_index), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);

    i_reset_n = 1'b1;
    rise = 0; vld_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      i_pipeline_state = 2'(c % 4);
      @(negedge i_clk);
      if (!o_ready && o_valid) vld_seen = 1'b1;
      if (o_ready) begin
        rise = c;
        break;
      end
    end
    i_pipeline_state = 2'd3;
    chk("ready_latency", 32'(rise), 32'd33);
    chk("valid_during_init", 32'(vld_seen), 32'd0);

    for (int i = 0; i < NROWS; i++) begin
      if (tbl[i].pre_nv) push(tbl[i].pre_on, tbl[i].voice);
      visit(tbl[i].voice, tbl[i].smp, tbl[i].exp, $sformatf("row%0d", i));
    end

    // FIFO: fill to 8, push+pop while full, then one push that must be dropped.
    push(1, 10); push(1, 12); push(0, 12); push(1, 11);
    push(1, 13); push(0, 13); push(1, 14); push(1, 16);
    chk("ovf_after_8", 32'(o_overflow), 32'd0);
    i_voice_index = 8'd20; i_sample = '0; i_pipeline_state = 2'd0;
    @(negedge i_clk);
    i_pipeline_state = 2'd1;
    @(negedge i_clk);
    i_pipeline_state = 2'd2; i_note_valid = 1'b1; i_note_on = 1'b1; i_note_voice = 8'd17;
    @(negedge i_clk);
    chk("ovf_full_push_pop", 32'(o_overflow), 32'd0);
    i_pipeline_state = 2'd3; i_note_voice = 8'd15;
    @(negedge i_clk);
    i_note_valid = 1'b0;
    chk("ovf_dropped", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 8; k++) visit(8'd20, 16'h0000, 16'h0000, $sformatf("drain%0d", k));
    for (int k = 0; k < 8; k++) begin
      visit(ov_voice[k], 16'h4000, 16'h0000, $sformatf("key%0d_v1", ov_voice[k]));
      visit(ov_voice[k], 16'h4000, 16'h0000, $sformatf("key%0d_v2", ov_voice[k]));
      visit(ov_voice[k], 16'h4000, ov_key[k] ? 16'h2000 : 16'h0000, $sformatf("key%0d_v3", ov_voice[k]));
    end
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Reset right after a phase-1 writeback of a saturated voice.
    i_voice_index = 8'd11; i_sample = 16'h4000; i_pipeline_state = 2'd0;
    @(negedge i_clk);
    i_pipeline_state = 2'd1;
    @(negedge i_clk);
    chk("pre_rst_smp", 32'(o_sample), 32'h3FFF);
    i_reset_n = 1'b0; i_pipeline_state = 2'd3;
    #1;
    chk("mid_rst_sample", 32'(o_sample), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_voice", 32'(o_voice_index), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    chk("mid_rst_ovf", 32'(o_overflow), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    wait_ready("reinit_ready");
    visit(8'd10, 16'h4000, 16'h0000, "reinit_v10");
    visit(8'd14, 16'h4000, 16'h0000, "reinit_v14");
    visit(8'd11, 16'h4000, 16'h0000, "reinit_v11a");
    visit(8'd11, 16'h4000, 16'h0000, "reinit_v11b");
    visit(8'd11, 16'h4000, 16'h0000, "reinit_v11c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
